// File: rtl/instruction_decoder.sv
// Instruction register and one-hot decoder for the accumulator CPU controller.
// It holds the IR, the latched condition flags, a sticky halt and a saturating executed-instruction count.
module instruction_decoder #(
    parameter int OPW = 4,
    parameter int ADW = 4,
    parameter int CW  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OPW+ADW-1:0]   mem_data,
    input  logic                 ir_load,
    input  logic                 flag_load,
    input  logic                 acc_zero,
    input  logic                 acc_neg,
    input  logic                 instr_done,
    output logic                 LDA,
    output logic                 STA,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 XOR,
    output logic                 INC,
    output logic                 CLR,
    output logic                 JMP,
    output logic                 JPZ,
    output logic                 JPN,
    output logic                 HLT,
    output logic [ADW-1:0]       operand,
    output logic                 take_jump,
    output logic                 illegal,
    output logic                 halted,
    output logic [CW-1:0]        instr_count
);

    localparam int IW = OPW + ADW;

    localparam logic [OPW-1:0] OP_LDA = OPW'(0);
    localparam logic [OPW-1:0] OP_STA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_INC = OPW'(5);
    localparam logic [OPW-1:0] OP_CLR = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);
    localparam logic [OPW-1:0] OP_JPZ = OPW'(8);
    localparam logic [OPW-1:0] OP_JPN = OPW'(9);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    logic [IW-1:0]  ir;
    logic           ir_valid;
    logic           zf;
    logic           nf;
    logic [OPW-1:0] opcode;

    assign opcode  = ir[IW-1:ADW];
    assign operand = ir[ADW-1:0];

    // Halt is decided from the pre-edge IR, so the edge that sets it still accepts loads and counts.
    // NOTE: non-blocking assignments let every register here see the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir          <= '0;
            ir_valid    <= 1'b0;
            zf          <= 1'b0;
            nf          <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else if (!halted) begin
            if (ir_load) begin
                ir       <= mem_data;
                ir_valid <= 1'b1;
            end
            if (flag_load) begin
                zf <= acc_zero;
                nf <= acc_neg;
            end
            if (instr_done && (instr_count != {CW{1'b1}})) begin
                instr_count <= instr_count + 1'b1;
            end
            if (ir_valid && (opcode == OP_HLT)) begin
                halted <= 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        LDA     = 1'b0;
        STA     = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        XOR     = 1'b0;
        INC     = 1'b0;
        CLR     = 1'b0;
        JMP     = 1'b0;
        JPZ     = 1'b0;
        JPN     = 1'b0;
        HLT     = 1'b0;
        illegal = 1'b0;
        if (ir_valid) begin
            case (opcode)
                OP_LDA:  LDA = 1'b1;
                OP_STA:  STA = 1'b1;
                OP_ADD:  ADD = 1'b1;
                OP_SUB:  SUB = 1'b1;
                OP_XOR:  XOR = 1'b1;
                OP_INC:  INC = 1'b1;
                OP_CLR:  CLR = 1'b1;
                OP_JMP:  JMP = 1'b1;
                OP_JPZ:  JPZ = 1'b1;
                OP_JPN:  JPN = 1'b1;
                OP_HLT:  HLT = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign take_jump = JMP | (JPZ & zf) | (JPN & nf);

endmodule
